pad_io_ctrl: RTL and testbench
==============================

Name: pad_io_ctrl

Overview:
Core-side controller for one bidirectional functional pad (OEN/I/O/PEN/PUEN/PAD style).
- Transmit: serialises core-requested drive values onto the pad. Each value is held for a fixed number of cycles. Break-before-make turnaround is inserted on every direction change.
- Receive: synchronises and deglitches the pad's O return and reports filtered level plus edge strobes.
- Sits between GPIO/bit-bang peripherals and the pad instance.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on pad_o_i (>=2).
- FILT_CYCLES, 4, consecutive stable synced cycles required before rx_o changes (>=1).
- HOLD_CYCLES, 4, cycles each accepted value is driven (>=1).
- TURN_CYCLES, 2, tri-state cycles inserted before first drive and after last drive (>=0; 0 skips the turnaround states).
- RX_RESET, 1'b1, reset value of rx_o and of the synchroniser/filter state.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- tx_valid_i, in, 1, drive request valid.
- tx_data_i, in, 1, value to drive.
- tx_od_i, in, 1, 1 = open-drain (drive only 0, release for 1); sampled with the data.
- tx_ready_o, out, 1, request accepted when tx_valid_i & tx_ready_o.
- busy_o, out, 1, FSM not in IDLE.
- pull_en_i, in, 1, enable the pad pull resistor.
- pull_up_i, in, 1, 1 = pull-up, 0 = pull-down.
- rx_o, out, 1, filtered pad level.
- rx_rise_o, out, 1, one-cycle pulse on rx_o 0->1.
- rx_fall_o, out, 1, one-cycle pulse on rx_o 1->0.
- pad_oen_o, out, 1, pad output enable, active low.
- pad_i_o, out, 1, pad drive value.
- pad_pen_o, out, 1, pad pull enable, active low (= ~pull_en_i, combinational).
- pad_puen_o, out, 1, pad pull select, 0 = up, 1 = down (= ~pull_up_i, combinational).
- pad_o_i, in, 1, pad O return.

Behaviour:
- Reset values: pad_oen_o=1, pad_i_o=0, tx_ready_o=1, busy_o=0, rx_o=RX_RESET, rx_rise_o=0, rx_fall_o=0. All synchroniser flops = RX_RESET. Filter counter = 0.
- pad_oen_o and pad_i_o are registered. Data and od are latched at the handshake.

FSM states:
- IDLE
  - tx_ready_o=1, pad_oen_o=1.
  - On handshake: go to TURN_ON (or DRIVE if TURN_CYCLES=0).
- TURN_ON
  - pad_oen_o=1 for exactly TURN_CYCLES cycles, then DRIVE.
- DRIVE
  - Push-pull: pad_oen_o=0, pad_i_o=data.
  - Open-drain: pad_i_o=0, pad_oen_o=data.
  - Hold counter runs 0..HOLD_CYCLES-1. tx_ready_o=1 only when the counter is HOLD_CYCLES-1.
  - Handshake at that point: latch the new data/od, restart the counter, stay in DRIVE. Back-to-back values have no gap and no turnaround.
  - No handshake: go to TURN_OFF (or IDLE if TURN_CYCLES=0).
- TURN_OFF
  - pad_oen_o=1 for TURN_CYCLES cycles, tx_ready_o=0, then IDLE.

Timing:
- Handshake at edge n: pad_oen_o is 1 through edge n+TURN_CYCLES and first drives after edge n+1+TURN_CYCLES.
- The value stays for exactly HOLD_CYCLES cycles.

Receive path:
- Synced value s = pad_o_i after SYNC_STAGES flops.
- s != rx_o: counter increments. At count FILT_CYCLES-1, the next edge sets rx_o=s and clears the counter.
- s == rx_o: counter clears.
- Latency from a clean pad_o_i step to rx_o = SYNC_STAGES+FILT_CYCLES cycles.
- rx_rise_o/rx_fall_o assert in the same cycle rx_o changes, for 1 cycle.
- The receive path runs in all states (loopback while driving is expected).

Boundaries:
- tx_valid_i may drop without handshake; no data is lost.
- Changes to pull_en_i/pull_up_i take effect immediately and are independent of the FSM.
- rst_i mid-DRIVE: pad released (pad_oen_o=1) after that edge, with no TURN_OFF.
- Counter widths = $clog2(max+1) with a minimum of 1.

Test Plan:
1. Single push-pull drive of 1, defaults: handshake at cycle 0 -> pad_oen_o=0, pad_i_o=1 on cycles 3..6; pad_oen_o=1 on 7..8; tx_ready_o back to 1 at cycle 9.
2. Back-to-back data 1,0,1 with tx_valid_i held -> pad_i_o=1,0,1 for 4 cycles each, pad_oen_o continuously 0 for 12 cycles, single turnaround before and after.
3. Open-drain data 1 then 0 -> pad_oen_o=1, pad_i_o=0 for 4 cycles; then pad_oen_o=0, pad_i_o=0 for 4 cycles.
4. Deglitch: pad_o_i from 1 to 0 for 3 cycles then back to 1 -> rx_o stays 1, no strobes. Steady 0 -> rx_o=0 after 6 cycles with a single rx_fall_o pulse.
5. Pull control: pull_en_i=1, pull_up_i=0 -> pad_pen_o=0, pad_puen_o=1 same cycle. Repeat mid-DRIVE -> FSM sequence unchanged.
6. Reset mid-DRIVE (cycle 4 of scenario 1) -> next cycle pad_oen_o=1, tx_ready_o=1, busy_o=0, rx_o=1.

Source files
------------

// File: rtl/pad_io_ctrl.sv
// Core-side controller for one bidirectional pad: timed, turnaround-guarded
// transmit of push-pull/open-drain values plus a synchronised, deglitched receive.
module pad_io_ctrl #(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CYCLES = 4,
   parameter int   HOLD_CYCLES = 4,
   parameter int   TURN_CYCLES = 2,
   parameter logic RX_RESET    = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tx_valid_i,
   input  logic tx_data_i,
   input  logic tx_od_i,
   output logic tx_ready_o,
   output logic busy_o,
   input  logic pull_en_i,
   input  logic pull_up_i,
   output logic rx_o,
   output logic rx_rise_o,
   output logic rx_fall_o,
   output logic pad_oen_o,
   output logic pad_i_o,
   output logic pad_pen_o,
   output logic pad_puen_o,
   input  logic pad_o_i
);

   localparam int CMAX =
      (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
   localparam int CW =
      ($clog2(CMAX + 1) < 1) ? 1 : $clog2(CMAX + 1);
   localparam int FW =
      ($clog2(FILT_CYCLES + 1) < 1) ? 1 : $clog2(FILT_CYCLES + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TURN_LAST =
      CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TURN_ON,
      S_DRIVE,
      S_TURN_OFF
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_data;
   logic            r_od;
   logic            w_data_nxt;
   logic            w_od_nxt;
   logic            r_oen;
   logic            r_pi;
   logic            w_oen_nxt;
   logic            w_pi_nxt;
   logic            w_hs;
   logic            w_hold_done;
   logic            w_turn_done;

   assign w_hold_done = (r_cnt == HOLD_LAST);
   assign w_turn_done = (r_cnt == TURN_LAST);

   assign tx_ready_o = (r_state == S_IDLE) ||
                       ((r_state == S_DRIVE) && w_hold_done);
   assign busy_o     = (r_state != S_IDLE);
   assign w_hs       = tx_valid_i & tx_ready_o;

   assign pad_oen_o  = r_oen;
   assign pad_i_o    = r_pi;
   assign pad_pen_o  = ~pull_en_i;
   assign pad_puen_o = ~pull_up_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_data  <= 1'b0;
         r_od    <= 1'b0;
         r_oen   <= 1'b1;
         r_pi    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_od    <= w_od_nxt;
         r_oen   <= w_oen_nxt;
         r_pi    <= w_pi_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_od_nxt    = r_od;
      w_oen_nxt   = 1'b1;
      w_pi_nxt    = 1'b0;

      if (w_hs) begin
         w_data_nxt = tx_data_i;
         w_od_nxt   = tx_od_i;
      end

      unique case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (TURN_CYCLES == 0) ? S_DRIVE : S_TURN_ON;
            end
         end
         S_TURN_ON: begin
            if (w_turn_done) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DRIVE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_DRIVE: begin
            if (w_hold_done) begin
               w_cnt_nxt = '0;
               if (!w_hs) begin
                  w_state_nxt =
                     (TURN_CYCLES == 0) ? S_IDLE : S_TURN_OFF;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_TURN_OFF: begin
            if (w_turn_done) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
      endcase

      // Pad pins are registered from the next state so they line up with it.
      if (w_state_nxt == S_DRIVE) begin
         w_oen_nxt = w_od_nxt ? w_data_nxt : 1'b0;
         w_pi_nxt  = w_od_nxt ? 1'b0 : w_data_nxt;
      end
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic [FW-1:0]          r_fcnt;
   logic                   r_rx;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_s;
   logic                   w_flip;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_flip = (w_s != r_rx) && (r_fcnt == FILT_LAST);

   assign rx_o      = r_rx;
   assign rx_rise_o = r_rise;
   assign rx_fall_o = r_fall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= {SYNC_STAGES{RX_RESET}};
         r_fcnt <= '0;
         r_rx   <= RX_RESET;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pad_o_i};
         r_rise <= w_flip & w_s;
         r_fall <= w_flip & ~w_s;
         if ((w_s == r_rx) || w_flip) begin
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + FW'(1);
         end
         if (w_flip) begin
            r_rx <= w_s;
         end
      end
   end

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Bench for pad_io_ctrl: directed scenarios plus random traffic, checked
// every cycle against a schedule/window reference model.
module tb_pad_io_ctrl;

   localparam int   SYNC = 2;
   localparam int   FILT = 4;
   localparam int   HOLD = 4;
   localparam int   TURN = 2;
   localparam logic RXR  = 1'b1;
   localparam int   N    = 4096;

   logic clk;
   logic rst;
   logic tx_valid;
   logic tx_data;
   logic tx_od;
   logic tx_ready;
   logic busy;
   logic pull_en;
   logic pull_up;
   logic rx;
   logic rx_rise;
   logic rx_fall;
   logic pad_oen;
   logic pad_i;
   logic pad_pen;
   logic pad_puen;
   logic pad_o;

   pad_io_ctrl #(
      .SYNC_STAGES(SYNC),
      .FILT_CYCLES(FILT),
      .HOLD_CYCLES(HOLD),
      .TURN_CYCLES(TURN),
      .RX_RESET(RXR)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .tx_valid_i(tx_valid),
      .tx_data_i(tx_data),
      .tx_od_i(tx_od),
      .tx_ready_o(tx_ready),
      .busy_o(busy),
      .pull_en_i(pull_en),
      .pull_up_i(pull_up),
      .rx_o(rx),
      .rx_rise_o(rx_rise),
      .rx_fall_o(rx_fall),
      .pad_oen_o(pad_oen),
      .pad_i_o(pad_i),
      .pad_pen_o(pad_pen),
      .pad_puen_o(pad_puen),
      .pad_o_i(pad_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   cyc;
   int   ep;
   int   n_vec;
   int   n_err;
   logic last_hs;

   logic e_oen  [N];
   logic e_pi   [N];
   logic e_rdy  [N];
   logic e_busy [N];
   logic e_rx   [N];
   logic e_rise [N];
   logic e_fall [N];
   logic pad_h  [N];

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d obs=%b exp=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_ph(input int k, input logic oen, input logic pi,
                         input logic rdy, input logic bsy);
      e_oen[k]  = oen;
      e_pi[k]   = pi;
      e_rdy[k]  = rdy;
      e_busy[k] = bsy;
   endtask

   // Handshake in cycle c: optional turn-on, HOLD drive cycles,
   // tentative turn-off, then idle.
   task automatic schedule(input int c, input logic d, input logic o);
      int st;
      st = c + 1;
      if (!e_busy[c]) begin
         for (int k = 1; k <= TURN; k++) set_ph(c + k, 1, 0, 0, 1);
         st = c + TURN + 1;
      end
      for (int k = 0; k < HOLD; k++)
         set_ph(st + k, o ? d : 1'b0, o ? 1'b0 : d, k == HOLD - 1, 1);
      for (int k = 0; k < TURN; k++)
         set_ph(st + HOLD + k, 1, 0, 0, 1);
      set_ph(st + HOLD + TURN, 1, 0, 1, 0);
   endtask

   function automatic logic s_at(input int t);
      if (t - SYNC >= ep) return pad_h[t - SYNC];
      return RXR;
   endfunction

   task automatic step();
      logic v;
      logic stable;
      pad_h[cyc] = pad_o;
      @(negedge clk);
      chk("pad_oen", pad_oen, e_oen[cyc]);
      chk("pad_i", pad_i, e_pi[cyc]);
      chk("tx_ready", tx_ready, e_rdy[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("rx", rx, e_rx[cyc]);
      chk("rx_rise", rx_rise, e_rise[cyc]);
      chk("rx_fall", rx_fall, e_fall[cyc]);
      chk("pad_pen", pad_pen, ~pull_en);
      chk("pad_puen", pad_puen, ~pull_up);
      last_hs = 1'b0;
      if (rst) begin
         for (int k = cyc + 1; k < N; k++) set_ph(k, 1, 0, 1, 0);
         ep = cyc + 1;
         e_rx[cyc + 1]   = RXR;
         e_rise[cyc + 1] = 1'b0;
         e_fall[cyc + 1] = 1'b0;
      end else begin
         if (tx_valid && e_rdy[cyc]) begin
            schedule(cyc, tx_data, tx_od);
            last_hs = 1'b1;
         end
         // rx follows s once s has held one differing value FILT cycles
         v = s_at(cyc);
         stable = 1'b1;
         for (int j = 0; j < FILT; j++)
            if (s_at(cyc - j) !== v) stable = 1'b0;
         if (stable && (v != e_rx[cyc])) begin
            e_rx[cyc + 1]   = v;
            e_rise[cyc + 1] = v;
            e_fall[cyc + 1] = ~v;
         end else begin
            e_rx[cyc + 1]   = e_rx[cyc];
            e_rise[cyc + 1] = 1'b0;
            e_fall[cyc + 1] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_tx(input logic [7:0] bits, input logic od,
                         input int n, input logic rnd_pull);
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         tx_valid = 1'b1;
         tx_data  = bits[i];
         tx_od    = od;
         do begin
            if (rnd_pull) begin
               pull_en = 1'($urandom);
               pull_up = 1'($urandom);
            end
            step();
            w++;
         end while (!last_hs && w < 40);
         chk("hs_seen", last_hs, 1'b1);
      end
      tx_valid = 1'b0;
      w = 0;
      while (e_busy[cyc] && w < 40) begin
         step();
         w++;
      end
      step();
   endtask

   initial begin
      int run;
      int c;
      int w;
      n_vec = 0;
      n_err = 0;
      ep = 0;
      cyc = 0;
      last_hs = 1'b0;
      for (int k = 0; k < N; k++) begin
         set_ph(k, 1, 0, 1, 0);
         e_rx[k]   = RXR;
         e_rise[k] = 1'b0;
         e_fall[k] = 1'b0;
         pad_h[k]  = 1'b0;
      end
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 1'b0;
      tx_od    = 1'b0;
      pull_en  = 1'b0;
      pull_up  = 1'b1;
      pad_o    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      step();
      run_tx(8'b0000_0001, 1'b0, 1, 1'b0);
      run_tx(8'b0000_0101, 1'b0, 3, 1'b0);
      run_tx(8'b0000_0001, 1'b1, 2, 1'b0);

      pad_o = 1'b1;
      repeat (5) step();
      pad_o = 1'b0;
      repeat (3) step();
      pad_o = 1'b1;
      repeat (10) step();
      pad_o = 1'b0;
      repeat (12) step();
      pad_o = 1'b1;
      repeat (10) step();

      pull_en = 1'b1;
      pull_up = 1'b0;
      step();
      pull_en = 1'b0;
      pull_up = 1'b1;
      step();
      run_tx(8'b0000_0011, 1'b0, 2, 1'b1);

      run = 0;
      repeat (1500) begin
         tx_valid = ($urandom_range(0, 3) != 0);
         tx_data  = 1'($urandom);
         tx_od    = 1'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            pull_en = 1'($urandom);
            pull_up = 1'($urandom);
         end
         if (run == 0) begin
            pad_o = 1'($urandom);
            run = $urandom_range(1, 8);
         end
         run--;
         step();
      end

      tx_valid = 1'b0;
      pad_o = 1'b1;
      w = 0;
      while (e_busy[cyc] && w < 40) begin
         step();
         w++;
      end
      step();
      tx_valid = 1'b1;
      tx_data  = 1'b1;
      tx_od    = 1'b0;
      w = 0;
      do begin
         step();
         w++;
      end while (!last_hs && w < 40);
      chk("hs_seen", last_hs, 1'b1);
      c = cyc - 1;
      tx_valid = 1'b0;
      while (cyc < c + 4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (8) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
